// File: rtl/contador_pkg.sv
// contador_pkg: shared state encoding and default width for the down-counter
package contador_pkg;
  typedef enum logic [1:0] {IDLE, RUN, PAUSA} estado_t;
  localparam int CONT_WIDTH_DEF = 4;
endpackage

// File: rtl/contador_descendente.sv
// contador_descendente: loadable down-counter with pause, cancel, auto-reload and a one-cycle done pulse
module contador_descendente
  import contador_pkg::*;
#(
  parameter int WIDTH = CONT_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] carga,
  input  logic             pausa,
  input  logic             cancelar,
  input  logic             recarga,
  output logic [WIDTH-1:0] Q,
  output logic             busy,
  output logic             done
);
  estado_t estado, next_estado;
  logic [WIDTH-1:0] carga_r, next_carga, next_q;
  logic next_done;
  logic terminal;
  assign terminal = Q == WIDTH'(1);
  assign busy = estado != IDLE;
  always_comb begin
    next_estado = estado;
    next_q = Q;
    next_carga = carga_r;
    next_done = 1'b0;
    case (estado)
      IDLE: if (start) begin
        next_q = carga;
        next_done = carga == '0;
        if (carga != '0) begin
          next_carga = carga;
          next_estado = RUN;
        end
      end
      RUN: if (cancelar) begin
        next_q = '0;
        next_estado = IDLE;
      end else if (pausa) begin
        next_estado = PAUSA;
      end else if (terminal) begin
        next_done = 1'b1;
        next_q = recarga ? carga_r : '0;
        next_estado = recarga ? RUN : IDLE;
      end else begin
        next_q = Q - 1'b1;
      end
      PAUSA: if (cancelar) begin
        next_q = '0;
        next_estado = IDLE;
      end else if (!pausa) begin
        next_estado = RUN;
      end
      default: next_estado = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      estado <= IDLE;
      Q <= '0;
      carga_r <= '0;
      done <= 1'b0;
    end else begin
      estado <= next_estado;
      Q <= next_q;
      carga_r <= next_carga;
      done <= next_done;
    end
  end
endmodule

// File: tb/tb_contador_descendente.sv
// tb_contador_descendente: scoreboard bench with directed scenarios and random stimulus
module tb_contador_descendente;
  logic clk = 1'b0;
  logic rst;
  logic start, pausa, cancelar, recarga;
  logic [3:0] carga;
  logic [3:0] Q;
  logic busy, done;
  int n_checks = 0;
  int n_fail = 0;
  typedef struct packed {logic [3:0] q; logic busy; logic done;} exp_t;
  exp_t sb[$];
  int m_q, m_rl;
  bit m_active, m_paused;

  contador_descendente #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .carga(carga), .pausa(pausa),
    .cancelar(cancelar), .recarga(recarga), .Q(Q), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Reference behaviour: a timer that is either idle, paused or running toward zero.
  task automatic step(input bit st, input int cg, input bit pa, input bit ca, input bit re);
    bit d;
    @(negedge clk);
    start = st; carga = 4'(cg); pausa = pa; cancelar = ca; recarga = re;
    d = 0;
    if (!m_active) begin
      if (st && cg == 0) begin m_q = 0; d = 1; end
      else if (st) begin m_q = cg; m_rl = cg; m_active = 1; m_paused = 0; end
    end else if (ca) begin
      m_q = 0; m_active = 0; m_paused = 0;
    end else if (m_paused) begin
      m_paused = pa;
    end else if (pa) begin
      m_paused = 1;
    end else if (m_q == 1) begin
      d = 1;
      if (re) m_q = m_rl;
      else begin m_q = 0; m_active = 0; end
    end else begin
      m_q = m_q - 1;
    end
    sb.push_back('{q: 4'(m_q), busy: m_active, done: d});
  endtask

  task automatic idle(input int n, input bit re = 0);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, re);
  endtask

  task automatic async_reset();
    @(negedge clk);
    rst = 1'b0;
    start = 0; pausa = 0; cancelar = 0; recarga = 0;
    #1;
    check("rst_Q", Q, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    m_q = 0; m_rl = 0; m_active = 0; m_paused = 0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("Q", Q, e.q);
        check("busy", busy, e.busy);
        check("done", done, e.done);
      end
    end
  end

  initial begin
    rst = 1'b0;
    start = 0; carga = 0; pausa = 0; cancelar = 0; recarga = 0;
    m_q = 0; m_rl = 0; m_active = 0; m_paused = 0;
    #2;
    check("init_Q", Q, 0);
    check("init_busy", busy, 0);
    check("init_done", done, 0);
    @(negedge clk);
    rst = 1'b1;
    step(1, 5, 0, 0, 0); idle(7);
    step(1, 0, 0, 0, 0); idle(2);
    step(1, 6, 0, 0, 0); idle(2);
    step(0, 0, 1, 0, 0); step(0, 0, 1, 0, 0); idle(6);
    step(1, 3, 0, 0, 1); idle(9, 1); idle(3);
    step(1, 9, 0, 0, 0); idle(1);
    step(1, 2, 0, 0, 0); step(0, 0, 0, 0, 0);
    step(0, 0, 1, 1, 0); idle(3);
    step(1, 9, 0, 0, 0); idle(3);
    async_reset(); idle(3);
    step(1, 15, 0, 0, 0); idle(16);
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 99) < 30, $urandom_range(0, 15), $urandom_range(0, 99) < 15,
           $urandom_range(0, 99) < 5, $urandom_range(0, 99) < 30);
    async_reset(); idle(4);
    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
    check("drain", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
